// File: rtl/ifetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ifetch : handshaked instruction fetch with next-PC selection.            |
// | Optional IFETCH_CNT_EN adds instr_cnt / stall_cnt saturating counters.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ifetch (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic [1:0]  NPCOp,
  input  logic [31:0] rs_data,
  input  logic        ex_done,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
`ifdef IFETCH_CNT_EN
  ,
  output logic [31:0] instr_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [31:0] c_RESET_PC  = 32'h0000_3000;
  localparam logic [1:0]  c_NPC_PLUS4 = 2'b00;
  localparam logic [1:0]  c_NPC_BR    = 2'b01;
  localparam logic [1:0]  c_NPC_J     = 2'b10;
  localparam logic [1:0]  c_NPC_JR    = 2'b11;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_fetch_err;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_off;
  logic [31:0] w_npc;
  logic        w_npc_misaligned;
  logic        w_accept;
  logic        w_capture;

  assign w_pc_plus4       = r_pc + 32'd4;
  assign w_br_off         = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_npc_misaligned = |w_npc[1:0];
  assign w_accept         = (r_state == S_VALID) && ex_done;
  assign w_capture        = (r_state == S_FETCH) && imem_ack;

  always_comb begin
    w_npc = w_pc_plus4;
    case (NPCOp)
      c_NPC_PLUS4: w_npc = w_pc_plus4;
      c_NPC_BR:    w_npc = w_pc_plus4 + w_br_off;
      c_NPC_J:     w_npc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
      c_NPC_JR:    w_npc = rs_data;
      default:     w_npc = w_pc_plus4;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: if (imem_ack) w_state_nxt = S_VALID;
      S_VALID: if (ex_done)  w_state_nxt = w_npc_misaligned ? S_HALT : S_FETCH;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_pc        <= c_RESET_PC;
      r_instr     <= 32'd0;
      r_fetch_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_instr <= imem_rdata;
      end
      // A misaligned target freezes pc so the faulting instruction stays visible.
      if (w_accept && !w_npc_misaligned) begin
        r_pc <= w_npc;
      end
      if (w_accept && w_npc_misaligned) begin
        r_fetch_err <= 1'b1;
      end
    end
  end

`ifdef IFETCH_CNT_EN
  logic [31:0] r_instr_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (w_accept && (r_instr_cnt != 32'hFFFF_FFFF)) begin
        r_instr_cnt <= r_instr_cnt + 32'd1;
      end
      if ((r_state == S_FETCH) && !imem_ack && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign instr_cnt = r_instr_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

  assign imem_req    = (r_state == S_FETCH);
  assign imem_addr   = r_pc;
  assign instr_valid = (r_state == S_VALID);
  assign instr       = r_instr;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign fetch_err   = r_fetch_err;

endmodule
`default_nettype wire

// File: tb/tb_ifetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ifetch : directed self-checking bench for ifetch (optionally with     |
// | IFETCH_CNT_EN). Rev 1.0                                                  |
// +--------------------------------------------------------------------------+
module tb_ifetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [1:0]  NPCOp;
  logic [31:0] rs_data;
  logic        ex_done;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;
`ifdef IFETCH_CNT_EN
  logic [31:0] instr_cnt;
  logic [31:0] stall_cnt;
`endif

  int n_total;
  int n_bad;

  ifetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .NPCOp       (NPCOp),
    .rs_data     (rs_data),
    .ex_done     (ex_done),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_err   (fetch_err)
`ifdef IFETCH_CNT_EN
    ,
    .instr_cnt   (instr_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; everything is driven and sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fetch one word (ack immediately) then retire it with the given NPC select.
  task automatic run_instr(input logic [31:0] word, input logic [1:0] op, input logic [31:0] rs);
    imem_ack = 1'b1; imem_rdata = word;
    tick();
    imem_ack = 1'b0; NPCOp = op; rs_data = rs; ex_done = 1'b1;
    tick();
    ex_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; NPCOp = 2'b00; rs_data = 32'd0; ex_done = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_total++; if (pc !== 32'h3000) begin n_bad++; $display("FAIL reset_pc got=%h want=%h", pc, 32'h3000); end
    n_total++; if (instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr got=%h want=%h", instr, 32'h0); end
    n_total++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", instr_valid); end
    n_total++; if (fetch_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", fetch_err); end
`ifdef IFETCH_CNT_EN
    n_total++; if (instr_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_icnt got=%0d want=0", instr_cnt); end
    n_total++; if (stall_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_scnt got=%0d want=0", stall_cnt); end
`endif
    tick();
    tick();
  endtask

  task automatic test_first_fetch();
    imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
    rst = 1'b0;
    #1;
    n_total++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL first_req got=%b want=1", imem_req); end
    n_total++; if (imem_addr !== 32'h3000) begin n_bad++; $display("FAIL first_addr got=%h want=%h", imem_addr, 32'h3000); end
    n_total++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL first_pre_valid got=%b want=0", instr_valid); end
    @(posedge clk); #1;
    n_total++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL first_valid got=%b want=1", instr_valid); end
    n_total++; if (instr !== 32'h2008_0005) begin n_bad++; $display("FAIL first_instr got=%h want=%h", instr, 32'h2008_0005); end
    n_total++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL first_req_valid got=%b want=0", imem_req); end
    n_total++; if (pc_plus4 !== 32'h3004) begin n_bad++; $display("FAIL first_pc4 got=%h want=%h", pc_plus4, 32'h3004); end
    // Hold in VALID: ack and new rdata must not disturb the held word.
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    n_total++; if (instr !== 32'h2008_0005) begin n_bad++; $display("FAIL hold_instr got=%h want=%h", instr, 32'h2008_0005); end
    n_total++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid got=%b want=1", instr_valid); end
    imem_ack = 1'b0; NPCOp = 2'b00; ex_done = 1'b1;
    tick();
    ex_done = 1'b0;
    n_total++; if (imem_addr !== 32'h3004) begin n_bad++; $display("FAIL plus4_addr got=%h want=%h", imem_addr, 32'h3004); end
    n_total++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL plus4_valid got=%b want=0", instr_valid); end
    n_total++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL plus4_req got=%b want=1", imem_req); end
  endtask

  task automatic test_branch();
    run_instr(32'h1000_FFFE, 2'b01, 32'd0);
    n_total++; if (imem_addr !== 32'h3000) begin n_bad++; $display("FAIL branch_addr got=%h want=%h", imem_addr, 32'h3000); end
  endtask

  task automatic test_jump();
    run_instr(32'h0000_0000, 2'b00, 32'd0);
    run_instr(32'h0000_0000, 2'b00, 32'd0);
    n_total++; if (pc !== 32'h3008) begin n_bad++; $display("FAIL jump_setup_pc got=%h want=%h", pc, 32'h3008); end
    run_instr(32'h0800_0C10, 2'b10, 32'd0);
    n_total++; if (imem_addr !== 32'h3040) begin n_bad++; $display("FAIL jump_addr got=%h want=%h", imem_addr, 32'h3040); end
  endtask

  task automatic test_reset_mid_valid();
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    n_total++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_valid got=%b want=1", instr_valid); end
    n_total++; if (pc !== 32'h3040) begin n_bad++; $display("FAIL midrst_pre_pc got=%h want=%h", pc, 32'h3040); end
    #2 rst = 1'b1;
    #1;
    n_total++; if (pc !== 32'h3000) begin n_bad++; $display("FAIL midrst_pc got=%h want=%h", pc, 32'h3000); end
    n_total++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got=%b want=0", instr_valid); end
    n_total++; if (instr !== 32'h0) begin n_bad++; $display("FAIL midrst_instr got=%h want=0", instr); end
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hAAAA_0001;
    rst = 1'b0;
    #1;
    n_total++; if (imem_addr !== 32'h3000 || imem_req !== 1'b1) begin n_bad++; $display("FAIL midrst_resume got=%h/%b want=%h/1", imem_addr, imem_req, 32'h3000); end
    @(posedge clk); #1;
    n_total++; if (instr !== 32'hAAAA_0001 || instr_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_refetch got=%h/%b want=%h/1", instr, instr_valid, 32'hAAAA_0001); end
    imem_ack = 1'b0; NPCOp = 2'b11; rs_data = 32'h3100; ex_done = 1'b1;
    tick();
    ex_done = 1'b0;
    n_total++; if (imem_addr !== 32'h3100) begin n_bad++; $display("FAIL jr_addr got=%h want=%h", imem_addr, 32'h3100); end
  endtask

  task automatic test_stall();
    // ex_done asserted in FETCH must be ignored.
    imem_ack = 1'b0; ex_done = 1'b1; NPCOp = 2'b11; rs_data = 32'h5000;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (imem_addr !== 32'h3100 || instr_valid !== 1'b0 || imem_req !== 1'b1)
        begin n_bad++; $display("FAIL stall_cyc%0d got addr=%h v=%b r=%b want addr=%h v=0 r=1", i, imem_addr, instr_valid, imem_req, 32'h3100); end
    end
    ex_done = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h3C01_0000;
`ifdef IFETCH_CNT_EN
    n_total++; if (stall_cnt !== 32'd3) begin n_bad++; $display("FAIL stall_cnt got=%0d want=3", stall_cnt); end
    n_total++; if (instr_cnt !== 32'd1) begin n_bad++; $display("FAIL instr_cnt1 got=%0d want=1", instr_cnt); end
`endif
    tick();
    imem_ack = 1'b0;
    n_total++; if (instr !== 32'h3C01_0000 || instr_valid !== 1'b1) begin n_bad++; $display("FAIL stall_capture got=%h/%b want=%h/1", instr, instr_valid, 32'h3C01_0000); end
  endtask

  task automatic test_misaligned();
    NPCOp = 2'b11; rs_data = 32'h3102; ex_done = 1'b1;
    tick();
    n_total++; if (fetch_err !== 1'b1) begin n_bad++; $display("FAIL mis_err got=%b want=1", fetch_err); end
    n_total++; if (pc !== 32'h3100) begin n_bad++; $display("FAIL mis_pc got=%h want=%h", pc, 32'h3100); end
    n_total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL mis_halt got req=%b v=%b want 0/0", imem_req, instr_valid); end
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF; NPCOp = 2'b00;
    for (int i = 0; i < 3; i++) tick();
    n_total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b1 || pc !== 32'h3100 || instr !== 32'h3C01_0000)
      begin n_bad++; $display("FAIL halt_hold got req=%b v=%b e=%b pc=%h i=%h", imem_req, instr_valid, fetch_err, pc, instr); end
`ifdef IFETCH_CNT_EN
    n_total++; if (instr_cnt !== 32'd2) begin n_bad++; $display("FAIL instr_cnt2 got=%0d want=2", instr_cnt); end
`endif
    ex_done = 1'b0; imem_ack = 1'b0;
    rst = 1'b1;
    #1;
    n_total++; if (fetch_err !== 1'b0 || pc !== 32'h3000) begin n_bad++; $display("FAIL halt_rst got e=%b pc=%h want 0/%h", fetch_err, pc, 32'h3000); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    run_instr(32'h0000_0000, 2'b11, 32'hFFFF_FFFC);
    n_total++; if (imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_jr got=%h want=%h", imem_addr, 32'hFFFF_FFFC); end
    n_total++; if (pc_plus4 !== 32'h0) begin n_bad++; $display("FAIL wrap_pc4 got=%h want=0", pc_plus4); end
    run_instr(32'h0000_0000, 2'b00, 32'd0);
    n_total++; if (imem_addr !== 32'h0 || fetch_err !== 1'b0) begin n_bad++; $display("FAIL wrap_plus4 got=%h/%b want=0/0", imem_addr, fetch_err); end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    test_reset();
    test_first_fetch();
    test_branch();
    test_jump();
    test_reset_mid_valid();
    test_stall();
    test_misaligned();
    test_wrap();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have: rst  in  1  asynchronous active-high reset.
REQ-003 SHALL have: imem_req  out  1  instruction-memory read request, held until acknowledged.
REQ-004 SHALL have: imem_addr  out  32  byte address of the requested word; always equals pc.
REQ-005 SHALL have: imem_ack  in  1  read data valid; meaningful only while imem_req=1.
REQ-006 SHALL have: imem_rdata  in  32  instruction word, sampled when imem_req&imem_ack.
REQ-007 SHALL have: NPCOp  in  2  next-PC select from the decoder: 00 PLUS4, 01 BRANCH, 10 JUMP, 11 JR.
REQ-008 SHALL have: rs_data  in  32  register value used as the JR/JALR target.
REQ-009 SHALL have: ex_done  in  1  the core has finished the current instruction; NPCOp and rs_data are valid this cycle.
REQ-010 SHALL have: instr  out  32  held instruction word, feeds Op/Funct/imm fields.
REQ-011 SHALL have: instr_valid  out  1  instr is valid for decode.
REQ-012 SHALL have: pc  out  32  address of the current instruction; pc_plus4  out  32  pc+4, for link writes.
REQ-013 SHALL have: fetch_err  out  1  sticky misaligned-target flag.

Function
REQ-014 SHALL have states FETCH, VALID and HALT; imem_req=1 only in FETCH; instr_valid=1 only in VALID.
REQ-015 In FETCH with imem_ack=1, SHALL capture imem_rdata into instr at that edge and enter VALID; with imem_ack=0 SHALL stay in FETCH with imem_addr stable.
REQ-016 SHALL achieve a minimum fetch latency of 1 cycle: req in cycle N, ack in N, instr_valid in N+1.
REQ-017 In VALID, instr and pc SHALL hold until ex_done=1; ex_done outside VALID SHALL be ignored.
REQ-018 On ex_done in VALID, SHALL load pc with NPC and enter FETCH the next cycle.
REQ-019 NPC SHALL be: PLUS4 pc+4; BRANCH pc+4+(sign-extended instr[15:0]<<2); JUMP {pc_plus4[31:28],instr[25:0],2'b00}; JR rs_data.
REQ-020 All NPC additions SHALL be modulo 2^32, with wrap-around permitted and not flagged.
REQ-021 If the selected NPC has bits[1:0]!=0 at ex_done, SHALL leave pc unchanged, set fetch_err, and enter HALT.
REQ-022 HALT SHALL be left only by reset; in HALT imem_req=0 and instr_valid=0.
REQ-023 imem_ack while imem_req=0 SHALL be ignored.

Reset
REQ-024 While rst=1, independent of clk: pc=32'h0000_3000, instr=0, state=FETCH, fetch_err=0, all counters 0.
REQ-025 After rst deasserts, imem_req SHALL be 1 from the first cycle; reset during FETCH wait or VALID SHALL abandon the instruction in progress.

Configuration
REQ-026 With `IFETCH_CNT_EN defined, SHALL add outputs instr_cnt (32) and stall_cnt (32). instr_cnt SHALL increment on each ex_done accepted in VALID. stall_cnt SHALL increment on each FETCH cycle with imem_ack=0. Both SHALL saturate at 32'hFFFF_FFFF.
REQ-027 With IFETCH_CNT_EN not defined, these ports and registers SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-028 The bench SHALL cover reset release with imem_ack tied 1, rdata=0x2008_0005: imem_addr=0x3000; instr=0x2008_0005 and instr_valid=1 one cycle later.
REQ-029 The bench SHALL cover pc=0x3004, instr=0x1000_FFFE, NPCOp=01 at ex_done: next imem_addr=0x3000.
REQ-030 The bench SHALL cover pc=0x3008, instr=0x0800_0C10, NPCOp=10: next imem_addr=0x0000_3040. It SHALL also cover NPCOp=11 with rs_data=0x3100, giving next imem_addr=0x3100.
REQ-031 The bench SHALL cover imem_ack held 0 for 3 cycles in FETCH: imem_addr stable, instr_valid=0, stall_cnt+=3 (with CNT_EN), and capture on the 4th cycle.
REQ-032 The bench SHALL cover NPCOp=11, rs_data=0x3102: fetch_err=1, state HALT, pc unchanged, imem_req=0 until rst.
REQ-033 The bench SHALL cover rst asserted mid-VALID at pc=0x3040: pc=0x3000 immediately, instr_valid=0, and fetch resuming at 0x3000.
